branch_resolve: RTL and testbench
=================================

# branch_resolve

Execute-stage branch resolution unit for the RISC-V core, directly downstream of the branch comparator. Drives the comparator's unsigned-select, consumes its `br_eq`/`br_lt` result and decodes the conditional-branch outcome. Compares that outcome against the fetch-time prediction and issues a registered redirect to fetch on mispredict. Owns a 2-bit saturating-counter branch history table (BHT) that fetch reads for predictions.

## Interface
- `BHT_ENTRIES`, 64, number of BHT counters; power of 2, ≥ 2; `IDX_W = log2(BHT_ENTRIES)`
- `clk` in 1: single clock; all state on rising edge
- `rst` in 1: synchronous, active-high reset
- `if_pc` in 32: fetch PC for prediction lookup
- `if_pred_taken` out 1: prediction for `if_pc`
- `ex_valid` in 1: execute-stage instruction valid
- `ex_is_branch` in 1: instruction is a conditional branch (opcode 1100011)
- `ex_funct3` in 3: branch funct3
- `ex_pc` in 32: branch PC
- `ex_target` in 32: computed branch target
- `ex_pred_taken` in 1: prediction carried from fetch with this instruction
- `br_un` out 1: unsigned-compare select to comparator
- `br_eq` in 1: comparator equal
- `br_lt` in 1: comparator less-than
- `redirect_valid` out 1: one-cycle redirect/flush pulse
- `redirect_pc` out 32: correct next PC
- `branch_cnt` out 32: resolved-branch count
- `mispredict_cnt` out 32: mispredict count

## Operation
- `br_un = ex_funct3[1]`, combinational.
- Accepted resolution: `res = ex_valid & ex_is_branch & ~redirect_valid`.
- Taken decode:
  - 000 BEQ: `br_eq`
  - 001 BNE: `~br_eq`
  - 100 BLT and 110 BLTU: `br_lt`
  - 101 BGE and 111 BGEU: `~br_lt`
  - 010 and 011 (illegal): not taken, and the BHT is not updated.
- Mispredict = `res & (taken != ex_pred_taken)`.
- Correct PC = `taken ? ex_target : ex_pc + 4`, computed mod 2^32 (0xFFFFFFFC + 4 = 0x00000000).
- BHT:
  - Array of `BHT_ENTRIES` 2-bit counters, indexed by `pc[IDX_W+1:2]`.
  - `if_pred_taken = bht[if_pc idx][1]`, combinational read of registered state.
  - Update on `res` with legal funct3: taken increments the counter, saturating at 11; not-taken decrements it, saturating at 00.
- Squash: when `redirect_valid` is high, any `ex_valid` in that cycle is wrong-path. It gets no redirect, no BHT update and no counting.
- Redirect/BHT/count decisions use only `br_eq`/`br_lt` sampled in the same cycle as `ex_valid`.

## Timing
- Reset:
  - `redirect_valid`=0, `redirect_pc`=0.
  - All BHT entries = 01 (weakly not-taken), so `if_pred_taken`=0 for every PC the cycle after reset.
  - Counters=0.
  - Reset asserted mid-redirect clears the pulse in that same edge.
- Resolution latency:
  - Mispredict at cycle N gives `redirect_valid`=1 and `redirect_pc` valid in cycle N+1.
  - `redirect_valid` deasserts in N+2 unless a new accepted mispredict occurred in N+1. That cannot happen, because the N+1 instruction is squashed.
  - `redirect_pc` holds its value when `redirect_valid`=0.
- BHT update written at edge ending cycle N. A lookup of the same index in cycle N returns the old value; a lookup in N+1 returns the new value.
- Correct prediction: no redirect, BHT still trained.

## Configuration
- `BRANCH_PERF_EN` defined:
  - `branch_cnt` increments on every accepted legal-funct3 resolution.
  - `mispredict_cnt` increments on every mispredict.
  - Both are registered, wrap at 2^32, and are cleared by `rst`.
- Not defined: both outputs tied to 32'h0 and no counter flops are inferred.

## Test plan
- Reset, then probe `if_pc`=0x100 and 0x3FC -> `if_pred_taken`=0; `redirect_valid`=0; both counters 0.
- BEQ (000) at `ex_pc`=0x100, `ex_target`=0x200, `br_eq`=1, `ex_pred_taken`=0 -> next cycle `redirect_valid`=1 and `redirect_pc`=0x200; BHT[0] 01->10; `if_pc`=0x100 predicts 1; `mispredict_cnt`=1.
- BGEU (111) at 0x104 -> `br_un`=1 that cycle. With `br_lt`=0, `ex_pred_taken`=1 -> no redirect; BHT[1] incremented; `branch_cnt` +1.
- Saturation: 4 taken BNE at 0x108 with `br_eq`=0 -> BHT[2]=11. One not-taken -> 10, still predicting taken. Then BLT not-taken with pred=0 at 0x108 -> 01, no redirect.
- Squash: mispredict BLT at 0x10C (taken, target 0x40, pred 0) in cycle N. A mispredicting BEQ at 0x110 in N+1 -> only one redirect pulse (0x40); BHT[4] unchanged; `mispredict_cnt` +1 only.
- Edge cases:
  - Illegal funct3 010 with pred=1 -> redirect to `ex_pc+4`, BHT untouched.
  - Not-taken BEQ at 0xFFFFFFFC with pred=1 -> `redirect_pc`=0x00000000.

Source files
------------

// File: rtl/branch_resolve.sv
// ---------------------------------------------------------------------------
// branch_resolve
//   Execute-stage conditional-branch resolution. It selects the comparator
//   mode, decodes taken/not-taken from br_eq/br_lt, checks the outcome against
//   the fetch-time prediction, and raises a one-cycle registered redirect on a
//   mispredict. It also holds the 2-bit saturating branch history table that
//   fetch reads for its predictions.
//
//   Optional feature: define BRANCH_PERF_EN to build the 32-bit resolved-branch
//   and mispredict counters. When it is not defined, both counter outputs are
//   tied to zero and no counter flops exist.
//
// Ports
//   clk, rst          : clock and synchronous active-high reset
//   if_pc             : fetch PC used for the BHT lookup
//   if_pred_taken     : prediction for if_pc (MSB of its counter)
//   ex_valid          : execute-stage instruction valid
//   ex_is_branch      : instruction is a conditional branch
//   ex_funct3         : branch condition
//   ex_pc, ex_target  : branch PC and computed taken target
//   ex_pred_taken     : prediction that travelled with the instruction
//   br_un             : unsigned-compare select to the comparator
//   br_eq, br_lt      : comparator results
//   redirect_valid    : one-cycle redirect/flush pulse
//   redirect_pc       : correct next PC (held while redirect_valid is low)
//   branch_cnt        : resolved legal branches
//   mispredict_cnt    : mispredicts
// ---------------------------------------------------------------------------
module branch_resolve #(
    parameter int BHT_ENTRIES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_pc,
    output logic        if_pred_taken,
    input  logic        ex_valid,
    input  logic        ex_is_branch,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_target,
    input  logic        ex_pred_taken,
    output logic        br_un,
    input  logic        br_eq,
    input  logic        br_lt,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic [31:0] branch_cnt,
    output logic [31:0] mispredict_cnt
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    logic [1:0]       bht_q [BHT_ENTRIES];
    logic [IDX_W-1:0] if_idx;
    logic [IDX_W-1:0] ex_idx;
    logic [1:0]       bht_cur;
    logic [1:0]       bht_entry_d;
    logic             bht_we;

    logic             redirect_valid_q, redirect_valid_d;
    logic [31:0]      redirect_pc_q, redirect_pc_d;

    logic             res;
    logic             taken;
    logic             legal;
    logic             mispredict;
    logic [31:0]      correct_pc;

    // PC bits that do not take part in BHT indexing.
    logic             unused_pc_bits;
    assign unused_pc_bits = ^{if_pc[31:IDX_W+2], if_pc[1:0]};

    assign if_idx = if_pc[IDX_W+1:2];
    assign ex_idx = ex_pc[IDX_W+1:2];

    // Comparator mode comes straight from funct3 so br_eq/br_lt are valid
    // in the same cycle.
    assign br_un         = ex_funct3[1];
    assign if_pred_taken = bht_q[if_idx][1];

    always_comb begin
        taken = 1'b0;
        legal = 1'b1;
        case (ex_funct3)
            3'b000:         taken = br_eq;
            3'b001:         taken = ~br_eq;
            3'b100, 3'b110: taken = br_lt;
            3'b101, 3'b111: taken = ~br_lt;
            default:        legal = 1'b0;   // 010/011: not taken, no training
        endcase
    end

    // An instruction arriving while a redirect is out is on the wrong path.
    assign res        = ex_valid & ex_is_branch & ~redirect_valid_q;
    assign mispredict = res & (taken != ex_pred_taken);
    assign correct_pc = taken ? ex_target : ex_pc + 32'd4;

    always_comb begin
        redirect_valid_d = mispredict;
        redirect_pc_d    = mispredict ? correct_pc : redirect_pc_q;
    end

    // Saturating counter update for the resolving branch's entry.
    always_comb begin
        bht_cur = bht_q[ex_idx];
        bht_we  = res & legal;
        if (taken) begin
            bht_entry_d = (bht_cur == 2'b11) ? 2'b11 : bht_cur + 2'd1;
        end else begin
            bht_entry_d = (bht_cur == 2'b00) ? 2'b00 : bht_cur - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= 32'h0;
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht_q[i] <= 2'b01;
            end
        end else begin
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            if (bht_we) begin
                bht_q[ex_idx] <= bht_entry_d;
            end
        end
    end

    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;

`ifdef BRANCH_PERF_EN
    logic [31:0] branch_cnt_q, branch_cnt_d;
    logic [31:0] mispredict_cnt_q, mispredict_cnt_d;

    always_comb begin
        branch_cnt_d     = branch_cnt_q + {31'h0, bht_we};
        mispredict_cnt_d = mispredict_cnt_q + {31'h0, mispredict};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            branch_cnt_q     <= 32'h0;
            mispredict_cnt_q <= 32'h0;
        end else begin
            branch_cnt_q     <= branch_cnt_d;
            mispredict_cnt_q <= mispredict_cnt_d;
        end
    end

    assign branch_cnt     = branch_cnt_q;
    assign mispredict_cnt = mispredict_cnt_q;
`else
    assign branch_cnt     = 32'h0;
    assign mispredict_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// ---------------------------------------------------------------------------
// tb_branch_resolve
//   Table-driven bench for branch_resolve. Each record holds the execute-stage
//   inputs, a fetch probe PC and hand-derived expected outputs. Post-edge
//   expectations are queued when a record is driven and popped one edge later.
//   A hand-written sequence covers reset arriving during a redirect pulse.
// ---------------------------------------------------------------------------
module tb_branch_resolve;

`ifdef BRANCH_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc;
    logic        if_pred_taken;
    logic        ex_valid;
    logic        ex_is_branch;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_pc;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic        br_un;
    logic        br_eq;
    logic        br_lt;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] branch_cnt;
    logic [31:0] mispredict_cnt;

    always #5 clk = ~clk;

    branch_resolve #(.BHT_ENTRIES(64)) dut (
        .clk            (clk),
        .rst            (rst),
        .if_pc          (if_pc),
        .if_pred_taken  (if_pred_taken),
        .ex_valid       (ex_valid),
        .ex_is_branch   (ex_is_branch),
        .ex_funct3      (ex_funct3),
        .ex_pc          (ex_pc),
        .ex_target      (ex_target),
        .ex_pred_taken  (ex_pred_taken),
        .br_un          (br_un),
        .br_eq          (br_eq),
        .br_lt          (br_lt),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .branch_cnt     (branch_cnt),
        .mispredict_cnt (mispredict_cnt)
    );

    typedef struct {
        logic        v;
        logic        br;
        logic [2:0]  f3;
        logic [31:0] pc;
        logic [31:0] tgt;
        logic        pred;
        logic        eq;
        logic        lt;
        logic [31:0] probe;
        logic        exp_un;
        logic        exp_pre;
        logic        exp_rv;
        logic [31:0] exp_rpc;
        logic        exp_post;
        int          exp_b;
        int          exp_m;
    } vec_t;

    typedef struct {
        int          id;
        logic        rv;
        logic [31:0] rpc;
        logic        post;
        int          b;
        int          m;
    } sb_t;

    vec_t vecs[$];
    sb_t  sbq[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s vec=%0d actual=0x%08h required=0x%08h", name, id, act, exp);
        end
    endtask

    function automatic logic [31:0] cnt(input int x);
        return PERF ? 32'(x) : 32'h0;
    endfunction

    function automatic void add(input logic v, input logic br, input logic [2:0] f3,
                                input logic [31:0] pc, input logic [31:0] tgt,
                                input logic pred, input logic eq, input logic lt,
                                input logic [31:0] probe, input logic exp_un,
                                input logic exp_pre, input logic exp_rv,
                                input logic [31:0] exp_rpc, input logic exp_post,
                                input int exp_b, input int exp_m);
        vec_t r;
        r.v = v; r.br = br; r.f3 = f3; r.pc = pc; r.tgt = tgt; r.pred = pred;
        r.eq = eq; r.lt = lt; r.probe = probe; r.exp_un = exp_un;
        r.exp_pre = exp_pre; r.exp_rv = exp_rv; r.exp_rpc = exp_rpc;
        r.exp_post = exp_post; r.exp_b = exp_b; r.exp_m = exp_m;
        vecs.push_back(r);
    endfunction

    task automatic idle_inputs();
        ex_valid = 1'b0; ex_is_branch = 1'b0; ex_funct3 = 3'b000;
        ex_pc = 32'h0; ex_target = 32'h0; ex_pred_taken = 1'b0;
        br_eq = 1'b0; br_lt = 1'b0;
    endtask

    initial begin
        // v  br f3      pc            tgt           pd eq lt probe         un pre rv rpc           post b   m
        add(1, 1, 3'b000, 32'h100,      32'h200,      0, 1, 0, 32'h100,      0, 0, 1, 32'h200,      1,  1, 1); // BEQ mispredict
        add(0, 0, 3'b000, 32'h0,        32'h0,        0, 0, 0, 32'h100,      0, 1, 0, 32'h200,      1,  1, 1); // pulse ends
        add(1, 1, 3'b111, 32'h104,      32'h300,      1, 0, 0, 32'h104,      1, 0, 0, 32'h200,      1,  2, 1); // BGEU correct
        add(1, 1, 3'b001, 32'h108,      32'h500,      1, 0, 0, 32'h108,      0, 0, 0, 32'h200,      1,  3, 1); // BNE 01->10
        add(1, 1, 3'b001, 32'h108,      32'h500,      1, 0, 0, 32'h108,      0, 1, 0, 32'h200,      1,  4, 1); // 10->11
        add(1, 1, 3'b001, 32'h108,      32'h500,      1, 0, 0, 32'h108,      0, 1, 0, 32'h200,      1,  5, 1); // sat 11
        add(1, 1, 3'b001, 32'h108,      32'h500,      1, 0, 0, 32'h108,      0, 1, 0, 32'h200,      1,  6, 1); // sat 11
        add(1, 1, 3'b001, 32'h108,      32'h500,      1, 1, 0, 32'h108,      0, 1, 1, 32'h10C,      1,  7, 2); // not taken 11->10
        add(0, 0, 3'b000, 32'h0,        32'h0,        0, 0, 0, 32'h108,      0, 1, 0, 32'h10C,      1,  7, 2);
        add(1, 1, 3'b100, 32'h108,      32'h600,      0, 0, 0, 32'h108,      0, 1, 0, 32'h10C,      0,  8, 2); // BLT nt 10->01
        add(1, 1, 3'b100, 32'h10C,      32'h40,       0, 0, 1, 32'h10C,      0, 0, 1, 32'h40,       1,  9, 3); // BLT mispredict
        add(1, 1, 3'b000, 32'h110,      32'h800,      0, 1, 0, 32'h110,      0, 0, 0, 32'h40,       0,  9, 3); // squashed BEQ
        add(0, 0, 3'b000, 32'h0,        32'h0,        0, 0, 0, 32'h110,      0, 0, 0, 32'h40,       0,  9, 3);
        add(1, 1, 3'b010, 32'h114,      32'h900,      1, 1, 1, 32'h114,      1, 0, 1, 32'h118,      0,  9, 4); // illegal 010
        add(0, 0, 3'b000, 32'h0,        32'h0,        0, 0, 0, 32'h114,      0, 0, 0, 32'h118,      0,  9, 4);
        add(1, 1, 3'b011, 32'h118,      32'hA00,      0, 1, 1, 32'h118,      1, 0, 0, 32'h118,      0,  9, 4); // illegal 011
        add(1, 1, 3'b000, 32'hFFFFFFFC, 32'h1000,     1, 0, 0, 32'h3FC,      0, 0, 1, 32'h0,        0, 10, 5); // PC wrap
        add(0, 0, 3'b000, 32'h0,        32'h0,        0, 0, 0, 32'h3FC,      0, 0, 0, 32'h0,        0, 10, 5);
        add(1, 1, 3'b101, 32'h120,      32'hA00,      1, 0, 1, 32'h120,      0, 0, 1, 32'h124,      0, 11, 6); // BGE mispredict
        add(1, 1, 3'b110, 32'h124,      32'hB00,      1, 0, 1, 32'h124,      1, 0, 0, 32'h124,      0, 11, 6); // squashed BLTU
        add(1, 1, 3'b110, 32'h124,      32'hB00,      1, 0, 1, 32'h124,      1, 0, 0, 32'h124,      1, 12, 6); // BLTU correct
        add(1, 0, 3'b000, 32'h128,      32'hC00,      0, 1, 0, 32'h128,      0, 0, 0, 32'h124,      0, 12, 6); // not a branch

        // Reset and its state.
        rst = 1'b1;
        idle_inputs();
        if_pc = 32'h100;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("rst_pred_100", -1, {31'h0, if_pred_taken}, 32'h0);
        check("rst_rv",       -1, {31'h0, redirect_valid}, 32'h0);
        check("rst_rpc",      -1, redirect_pc, 32'h0);
        check("rst_bcnt",     -1, branch_cnt, 32'h0);
        check("rst_mcnt",     -1, mispredict_cnt, 32'h0);
        if_pc = 32'h3FC;
        #1;
        check("rst_pred_3fc", -1, {31'h0, if_pred_taken}, 32'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            sb_t e;
            ex_valid = vecs[i].v; ex_is_branch = vecs[i].br; ex_funct3 = vecs[i].f3;
            ex_pc = vecs[i].pc; ex_target = vecs[i].tgt; ex_pred_taken = vecs[i].pred;
            br_eq = vecs[i].eq; br_lt = vecs[i].lt; if_pc = vecs[i].probe;
            #1;
            check("br_un",    i, {31'h0, br_un}, {31'h0, vecs[i].exp_un});
            check("pred_pre", i, {31'h0, if_pred_taken}, {31'h0, vecs[i].exp_pre});
            e.id = i; e.rv = vecs[i].exp_rv; e.rpc = vecs[i].exp_rpc;
            e.post = vecs[i].exp_post; e.b = vecs[i].exp_b; e.m = vecs[i].exp_m;
            sbq.push_back(e);
            @(posedge clk);
            #1;
            if (sbq.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL scoreboard_empty vec=%0d", i);
            end else begin
                sb_t x;
                x = sbq.pop_front();
                check("redirect_valid", x.id, {31'h0, redirect_valid}, {31'h0, x.rv});
                check("redirect_pc",    x.id, redirect_pc, x.rpc);
                check("pred_post",      x.id, {31'h0, if_pred_taken}, {31'h0, x.post});
                check("branch_cnt",     x.id, branch_cnt, cnt(x.b));
                check("mispredict_cnt", x.id, mispredict_cnt, cnt(x.m));
            end
        end

        // Reset arriving while a redirect pulse is out clears it on that edge.
        ex_valid = 1'b1; ex_is_branch = 1'b1; ex_funct3 = 3'b000;
        ex_pc = 32'h100; ex_target = 32'h200; ex_pred_taken = 1'b0;
        br_eq = 1'b1; br_lt = 1'b0; if_pc = 32'h104;
        @(posedge clk);
        #1;
        check("mid_rv_set",   100, {31'h0, redirect_valid}, 32'h1);
        check("mid_rpc_set",  100, redirect_pc, 32'h200);
        check("mid_pred_104", 100, {31'h0, if_pred_taken}, 32'h1);
        idle_inputs();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mid_rst_rv",   101, {31'h0, redirect_valid}, 32'h0);
        check("mid_rst_rpc",  101, redirect_pc, 32'h0);
        check("mid_rst_bcnt", 101, branch_cnt, 32'h0);
        check("mid_rst_mcnt", 101, mispredict_cnt, 32'h0);
        check("mid_rst_pred", 101, {31'h0, if_pred_taken}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
